// File: rtl/onehot_decoder_seq.sv
// Registered SEL_W-to-2**SEL_W one-hot decoder with enable, valid-qualified load,
// hold, and an up/down auto-scan mode with a programmable dwell per step.
module onehot_decoder_seq #(
    parameter int SEL_W      = 3,
    parameter int DWELL_W    = 8,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [1:0]              mode,
    input  logic                    sel_valid,
    input  logic [SEL_W-1:0]        sel,
    input  logic [DWELL_W-1:0]      dwell,
    output logic [(2**SEL_W)-1:0]   y,
    output logic                    y_valid,
    output logic [SEL_W-1:0]        idx,
    output logic                    wrap
);

    localparam int OUT_W = 2**SEL_W;
    localparam logic [OUT_W-1:0] BLANK = {OUT_W{ACTIVE_LOW}};
    localparam logic [OUT_W-1:0] ONE   = {{(OUT_W-1){1'b0}}, 1'b1};

    typedef enum logic {IDLE, RUN} state_t;
    typedef enum logic [1:0] {DECODE = 2'b00, SCAN_UP = 2'b01, SCAN_DOWN = 2'b10, HOLD = 2'b11} mode_t;

    state_t             state_q, state_d;
    mode_t              mode_q, mode_d;
    logic [SEL_W-1:0]   idx_q, idx_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               valid_d, wrap_d;
    logic [OUT_W-1:0]   y_q, y_d;
    logic               valid_q, wrap_q;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        mode_d  = mode_t'(mode);
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        wrap_d  = 1'b0;

        if (!en) begin
            state_d = IDLE;
            valid_d = 1'b0;
            cnt_d   = '0;
        end else if (sel_valid) begin
            state_d = RUN;
            valid_d = 1'b1;
            idx_d   = sel;
            cnt_d   = '0;
        end else if (state_q == IDLE) begin
            // Re-entry shows the retained index without stepping, whatever the mode.
            state_d = RUN;
            valid_d = 1'b1;
            cnt_d   = '0;
        end else if (mode_t'(mode) != mode_q) begin
            cnt_d = '0;
        end else begin
            case (mode_t'(mode))
                DECODE: cnt_d = '0;
                SCAN_UP, SCAN_DOWN: begin
                    // Live >= compare: lowering dwell below the counter forces a step.
                    if (cnt_q >= dwell) begin
                        cnt_d = '0;
                        if (mode_t'(mode) == SCAN_UP) begin
                            idx_d  = idx_q + SEL_W'(1);
                            wrap_d = (idx_q == '1);
                        end else begin
                            idx_d  = idx_q - SEL_W'(1);
                            wrap_d = (idx_q == '0);
                        end
                    end else begin
                        cnt_d = cnt_q + DWELL_W'(1);
                    end
                end
                HOLD: ;
            endcase
        end

        y_d = valid_d ? ((ONE << idx_d) ^ BLANK) : BLANK;
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: every register here is small control state, so all of it is reset.
            state_q <= IDLE;
            mode_q  <= DECODE;
            idx_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            y_q     <= BLANK;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
            y_q     <= y_d;
        end
    end

    assign y       = y_q;
    assign y_valid = valid_q;
    assign idx     = idx_q;
    assign wrap    = wrap_q;

endmodule
